// File: rtl/alu_arbiter_if.sv
// Requester/response bundle for alu_arbiter: two requesters, each with a
// valid/ready request channel (a, b, op) and a valid/ready response channel.
//   master : requester side (drives requests, consumes responses)
//   slave  : arbiter side (accepts requests, produces responses)
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_op;
    logic             rsp0_valid;
    logic [WIDTH-1:0] rsp0_data;
    logic             rsp0_ready;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_op;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp1_data;
    logic             rsp1_ready;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// One operation in flight: IDLE (accept) -> EXEC (operands on ALU) -> RESP
// (result held until the owner's rsp handshake). Minimum 3 cycles per op.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   bus          alu_arbiter_if.slave (req0/req1 and rsp0/rsp1 channels)
//   alu_in1/2    registered operands to the shared ALU
//   alu_control  registered op to the shared ALU (1 = a << b, 0 = pass a)
//   alu_result   combinational ALU result, captured at end of EXEC
//   busy         high whenever the FSM is not IDLE
//
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// wins every tie); otherwise ties are resolved round-robin.
module alu_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic             alu_control,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             op_q;
    logic             owner_q;
    logic [WIDTH-1:0] result_q;

    logic             grant0_c;
    logic             grant1_c;
    logic             accept_c;
    logic             rsp_done_c;

    // Grant selection: a lone valid wins; ties go to fixed or rotating priority
`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant1_c = bus.req1_valid && !bus.req0_valid;
`else
    logic last_q;   // requester served last; reset to 1 so requester 0 wins first tie

    assign grant1_c = bus.req1_valid && (!bus.req0_valid || !last_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept_c) begin
            last_q <= grant1_c;
        end
    end
`endif

    assign grant0_c   = bus.req0_valid && !grant1_c;
    assign accept_c   = (state_q == IDLE) && (grant0_c || grant1_c);
    assign rsp_done_c = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)   state_d = EXEC;
            EXEC:                    state_d = RESP;
            RESP:    if (rsp_done_c) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Output decode; ready and rsp_valid are masked while reset is asserted
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        busy           = 1'b0;
        if (rst_n) begin
            bus.req0_ready = (state_q == IDLE) && grant0_c;
            bus.req1_ready = (state_q == IDLE) && grant1_c;
            bus.rsp0_valid = (state_q == RESP) && !owner_q;
            bus.rsp1_valid = (state_q == RESP) &&  owner_q;
        end
        busy = (state_q != IDLE);
    end

    // Operand/owner capture on accept, result capture at end of EXEC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            owner_q  <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept_c) begin
                a_q     <= grant1_c ? bus.req1_a  : bus.req0_a;
                b_q     <= grant1_c ? bus.req1_b  : bus.req0_b;
                op_q    <= grant1_c ? bus.req1_op : bus.req0_op;
                owner_q <= grant1_c;
            end
            if (state_q == EXEC) begin
                result_q <= alu_result;
            end
        end
    end

    // Operands hold their last accepted values outside EXEC
    assign alu_in1       = a_q;
    assign alu_in2       = b_q;
    assign alu_control   = op_q;
    assign bus.rsp0_data = result_q;
    assign bus.rsp1_data = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. A negedge monitor pushes expected
// results on every request accept and compares them when a response appears.
module tb_alu_arbiter;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic             alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             busy;

    alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .busy        (busy)
    );

    // Shared combinational ALU
    assign alu_result = alu_control ? WIDTH'(alu_in1 << alu_in2) : alu_in1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic             owner;
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   order_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic op);
        logic [15:0] wide;
        wide = {8'h00, a} << b;
        return op ? wide[7:0] : a;
    endfunction

    // Scoreboard monitor
    logic prev_any = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        logic any;
        logic own;
        logic [WIDTH-1:0] dat;
        if (!rst_n) begin
            prev_any = 1'b0;
        end else begin
            if (bus.req0_valid && bus.req0_ready) begin
                e.owner = 1'b0; e.data = model(bus.req0_a, bus.req0_b, bus.req0_op); e.cyc = cyc;
                sb.push_back(e);
                order_log.push_back(0);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                e.owner = 1'b1; e.data = model(bus.req1_a, bus.req1_b, bus.req1_op); e.cyc = cyc;
                sb.push_back(e);
                order_log.push_back(1);
            end
            any = bus.rsp0_valid || bus.rsp1_valid;
            if (bus.rsp0_valid && bus.rsp1_valid) check("rsp_exclusive", 32'd1, 32'd0);
            if (any) begin
                if (sb.size() == 0) begin
                    check("rsp_spurious", 32'd1, 32'd0);
                end else begin
                    own = bus.rsp1_valid;
                    dat = own ? bus.rsp1_data : bus.rsp0_data;
                    if (!prev_any) check("rsp_latency", 32'(cyc), 32'(sb[0].cyc + 2));
                    check("rsp_owner", 32'(own), 32'(sb[0].owner));
                    check("rsp_data", 32'(dat), 32'(sb[0].data));
                    if (own ? bus.rsp1_ready : bus.rsp0_ready) void'(sb.pop_front());
                end
            end
            prev_any = any;
        end
    end

    task automatic set_req(input int idx, input logic v, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic op);
        if (idx == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
    endtask

    // Present a request and return #1 after its accepting edge (in EXEC);
    // operands are scrambled afterwards to show they are not re-sampled.
    task automatic drive_req(input int idx, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic op);
        bit done = 1'b0;
        @(negedge clk);
        set_req(idx, 1'b1, a, b, op);
        for (int k = 0; k < 50 && !done; k++) begin
            #1;
            if ((idx == 0) ? bus.req0_ready : bus.req1_ready) begin
                @(posedge clk);
                #1;
                set_req(idx, 1'b0, ~a, ~b, ~op);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            check("req_accept_timeout", 32'd0, 32'd1);
            set_req(idx, 1'b0, a, b, op);
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            #1;
            if (!busy && sb.size() == 0) done = 1'b1;
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        order_log.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_req(0, 1'b1, 8'h00, 8'h00, 1'b0);
        set_req(1, 1'b1, 8'h00, 8'h00, 1'b0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;

        // Reset: both ready low even with valid requests pending
        repeat (3) begin
            @(negedge clk);
            check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
            check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
        end
        set_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        check("rst_rsp0_data", 32'(bus.rsp0_data), 32'd0);
        check("rst_alu_in1", 32'(alu_in1), 32'd0);
        check("rst_alu_in2", 32'(alu_in2), 32'd0);
        check("rst_alu_control", 32'(alu_control), 32'd0);

        // Shift op on requester 0; ALU inputs visible in EXEC
        drive_req(0, 8'h03, 8'h02, 1'b1);
        @(negedge clk);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_alu_in1", 32'(alu_in1), 32'h03);
        check("exec_alu_in2", 32'(alu_in2), 32'h02);
        check("exec_alu_control", 32'(alu_control), 32'd1);
        check("exec_req1_ready", 32'(bus.req1_ready), 32'd0);
        check("exec_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        wait_idle();

        // Pass op on requester 1; operands held once idle again
        drive_req(1, 8'hA5, 8'h07, 1'b0);
        wait_idle();
        check("idle_alu_in1_hold", 32'(alu_in1), 32'hA5);
        check("idle_alu_in2_hold", 32'(alu_in2), 32'h07);
        check("idle_alu_control_hold", 32'(alu_control), 32'd0);

        // rsp_ready high while idle does nothing
        repeat (2) @(negedge clk);
        check("idle_rsp_ready_noeffect", 32'(busy), 32'd0);

        // Continuous contention after reset: service order
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 8'h05, 8'h01, 1'b1);
        set_req(1, 1'b1, 8'h33, 8'h00, 1'b0);
        for (int k = 0; k < 40 && order_log.size() < 4; k++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 8'h00, 1'b0);
        wait_idle();
        check("order_count", 32'(order_log.size()), 32'd4);
        if (order_log.size() >= 4) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            check("order_0", 32'(order_log[0]), 32'd0);
            check("order_1", 32'(order_log[1]), 32'd0);
            check("order_2", 32'(order_log[2]), 32'd0);
            check("order_3", 32'(order_log[3]), 32'd0);
`else
            check("order_0", 32'(order_log[0]), 32'd0);
            check("order_1", 32'(order_log[1]), 32'd1);
            check("order_2", 32'(order_log[2]), 32'd0);
            check("order_3", 32'(order_log[3]), 32'd1);
`endif
        end

        // Backpressure: response held 5 cycles, req1 blocked until after handshake
        bus.rsp0_ready = 1'b0;
        drive_req(0, 8'h81, 8'h01, 1'b1);
        set_req(1, 1'b1, 8'hA5, 8'h07, 1'b0);
        repeat (6) begin
            @(negedge clk);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        check("hs_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        check("hs_req1_ready", 32'(bus.req1_ready), 32'd0);
        @(negedge clk);
        check("post_hs_busy", 32'(busy), 32'd0);
        check("post_hs_req1_ready", 32'(bus.req1_ready), 32'd1);
        @(posedge clk);
        #1;
        set_req(1, 1'b0, 8'h00, 8'h00, 1'b0);
        wait_idle();

        // Reset in EXEC abandons the operation
        drive_req(0, 8'h01, 8'h01, 1'b1);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abandon_busy", 32'(busy), 32'd0);
            check("abandon_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
            check("abandon_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        end
        drive_req(0, 8'h01, 8'h09, 1'b1);
        wait_idle();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
